// File: rtl/pulse_pattern_checker.sv
`default_nettype none
// ============================================================================
// pulse_pattern_checker : run-length checker for the square-wave test pattern.
// Optional 2-flop input synchronizer: define PPC_INPUT_SYNC_EN.  Rev 1.0
// ============================================================================
module pulse_pattern_checker #(
  parameter int HALF_PERIOD = 10,
  parameter int TOL         = 0,
  parameter int LOCK_RUNS   = 4,
  parameter int CNT_W       = 5,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  output logic             lock,
  output logic             err,
  output logic [CNT_W-1:0] last_len,
  output logic             last_lvl,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_RUNS + 1);
  localparam logic [CNT_W-1:0]  RUN_MIN  = CNT_W'(HALF_PERIOD - TOL);
  localparam logic [CNT_W-1:0]  RUN_MAX  = CNT_W'(HALF_PERIOD + TOL);
  localparam logic [CNT_W-1:0]  RUN_OVF  = CNT_W'(HALF_PERIOD + TOL + 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_RUNS);
  localparam logic [ERR_W-1:0]  ERR_SAT  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic              lock_nxt, err_nxt, lvl_nxt;
  logic [CNT_W-1:0]  len_nxt;
  logic              d_in, d_q, d_prev, edge_seen, run_good;
  logic [CNT_W-1:0]  run_cnt;

`ifdef PPC_INPUT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign d_in = sync_q[1];
`else
  assign d_in = d;
`endif

  assign edge_seen = d_q ^ d_prev;
  assign run_good  = (run_cnt >= RUN_MIN) && (run_cnt <= RUN_MAX);

  // Run counter saturates one past the longest good run so timeouts stay visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q     <= 1'b0;
      d_prev  <= 1'b0;
      run_cnt <= '0;
    end else begin
      d_q    <= d_in;
      d_prev <= d_q;
      if (edge_seen) begin
        run_cnt <= CNT_W'(1);
      end else if (run_cnt != RUN_OVF) begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    lock_nxt  = lock;
    err_nxt   = 1'b0;
    len_nxt   = last_len;
    lvl_nxt   = last_lvl;
    case (state)
      IDLE: begin
        if (edge_seen) begin
          state_nxt = MEASURE;
          good_nxt  = '0;
        end
      end
      MEASURE, LOCKED: begin
        if (edge_seen) begin
          len_nxt = run_cnt;
          lvl_nxt = d_prev;
          if (run_good) begin
            if (state == MEASURE) begin
              good_nxt = good_cnt + 1'b1;
              if (good_cnt == GOOD_TGT - 1'b1) begin
                state_nxt = LOCKED;
                lock_nxt  = 1'b1;
              end
            end
          end else begin
            err_nxt   = 1'b1;
            good_nxt  = '0;
            lock_nxt  = 1'b0;
            state_nxt = MEASURE;
          end
        end else if (run_cnt == RUN_MAX) begin
          // Stuck input: report once, then wait for a fresh edge in IDLE.
          err_nxt   = 1'b1;
          len_nxt   = RUN_OVF;
          lvl_nxt   = d_q;
          lock_nxt  = 1'b0;
          good_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        good_nxt  = '0;
        lock_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      good_cnt <= '0;
      lock     <= 1'b0;
      err      <= 1'b0;
      last_len <= '0;
      last_lvl <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      lock     <= lock_nxt;
      err      <= err_nxt;
      last_len <= len_nxt;
      last_lvl <= lvl_nxt;
      if (err_nxt && (err_cnt != ERR_SAT)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_pattern_checker.sv
`default_nettype none
// tb_pulse_pattern_checker : scoreboard bench driving one pattern into three
// checker instances (defaults, TOL=1, ERR_W=2) and checking the selected one.
module tb_pulse_pattern_checker;

`ifdef PPC_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic d     = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       lock_a, err_a, lvl_a, lock_b, err_b, lvl_b, lock_c, err_c, lvl_c;
  logic [4:0] len_a, len_b, len_c;
  logic [7:0] ecnt_a, ecnt_b;
  logic [1:0] ecnt_c;

  pulse_pattern_checker u_def (
    .clk(clk), .rst_n(rst_n), .d(d), .lock(lock_a), .err(err_a),
    .last_len(len_a), .last_lvl(lvl_a), .err_cnt(ecnt_a));

  pulse_pattern_checker #(.TOL(1)) u_tol (
    .clk(clk), .rst_n(rst_n), .d(d), .lock(lock_b), .err(err_b),
    .last_len(len_b), .last_lvl(lvl_b), .err_cnt(ecnt_b));

  pulse_pattern_checker #(.ERR_W(2)) u_e2 (
    .clk(clk), .rst_n(rst_n), .d(d), .lock(lock_c), .err(err_c),
    .last_len(len_c), .last_lvl(lvl_c), .err_cnt(ecnt_c));

  int          sel = 0;
  logic        obs_lock, obs_err, obs_lvl;
  logic [31:0] obs_len, obs_ecnt;

  always_comb begin
    obs_lock = lock_a;
    obs_err  = err_a;
    obs_lvl  = lvl_a;
    obs_len  = {27'b0, len_a};
    obs_ecnt = {24'b0, ecnt_a};
    if (sel == 1) begin
      obs_lock = lock_b; obs_err = err_b; obs_lvl = lvl_b;
      obs_len  = {27'b0, len_b}; obs_ecnt = {24'b0, ecnt_b};
    end else if (sel == 2) begin
      obs_lock = lock_c; obs_err = err_c; obs_lvl = lvl_c;
      obs_len  = {27'b0, len_c}; obs_ecnt = {30'b0, ecnt_c};
    end
  end

  typedef struct {
    int   due;
    logic err;
    logic lock;
    logic chk;
    int   len;
    logic lvl;
    int   ecnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   prev_len, exp_ecnt, ecnt_max, run_max, seen_ecnt;
  logic prev_lvl, seen_lock;
  bit   stim_done;

  task automatic step(input logic v);
    d = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int s, input int mx, input int emax);
    sel = s; run_max = mx; ecnt_max = emax;
    rst_n = 1'b0; step(1'b0); step(1'b0);
    rst_n = 1'b1; step(1'b0); step(1'b0);
    sb.delete();
    prev_lvl = 1'b0; prev_len = 0; exp_ecnt = 0;
    seen_lock = 1'b0; seen_ecnt = 0;
  endtask

  // Drives one run; the edge that opens it closes the previous run, whose
  // expected judgement is given by the caller. tmo adds the stuck-input error.
  task automatic put_run(input logic lvl, input int len, input logic judged,
                         input logic e_err, input logic e_lock, input logic tmo);
    exp_t e;
    if (lvl != prev_lvl) begin
      if (e_err && exp_ecnt < ecnt_max) exp_ecnt++;
      e.due = cyc + 2 + SYNC_LAT; e.err = e_err; e.lock = e_lock; e.chk = judged;
      e.len = prev_len; e.lvl = prev_lvl; e.ecnt = exp_ecnt;
      sb.push_back(e);
    end
    if (tmo) begin
      if (exp_ecnt < ecnt_max) exp_ecnt++;
      e.due = cyc + 2 + SYNC_LAT + run_max; e.err = 1'b1; e.lock = 1'b0; e.chk = 1'b1;
      e.len = run_max + 1; e.lvl = lvl; e.ecnt = exp_ecnt;
      sb.push_back(e);
    end
    for (int i = 0; i < len; i++) step(lvl);
    prev_lvl = lvl;
    prev_len = len;
  endtask

  task automatic test_reset();
    sel = 0;
    rst_n = 1'b0; step(1'b1); step(1'b1);
    n_chk++;
    if ({lock_a, err_a, len_a, lvl_a, ecnt_a} !== 16'h0) begin
      n_fail++; $display("FAIL reset_def: got %b want all zero", {lock_a, err_a, len_a, lvl_a, ecnt_a});
    end
    n_chk++;
    if ({lock_b, err_b, len_b, lvl_b, ecnt_b} !== 16'h0) begin
      n_fail++; $display("FAIL reset_tol: got %b want all zero", {lock_b, err_b, len_b, lvl_b, ecnt_b});
    end
    n_chk++;
    if ({lock_c, err_c, len_c, lvl_c, ecnt_c} !== 10'h0) begin
      n_fail++; $display("FAIL reset_e2: got %b want all zero", {lock_c, err_c, len_c, lvl_c, ecnt_c});
    end
  endtask

  task automatic test_lock_and_short();
    exp_t e;
    int   guard;
    do_reset(0, 10, 255);
    stim_done = 1'b0;
    fork
      begin
        put_run(1, 10, 0, 0, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 1, 0);
        put_run(0, 10, 1, 0, 1, 0);
        put_run(1,  9, 1, 0, 1, 0);
        put_run(0, 10, 1, 1, 0, 0);
        put_run(1, 10, 1, 0, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 0, 0);
        put_run(0, 10, 1, 0, 1, 0);
        put_run(1, 10, 1, 0, 1, 0);
        stim_done = 1'b1;
      end
      begin
        guard = 0;
        while ((!stim_done || sb.size() != 0) && guard < 2000) begin
          @(posedge clk); #2; guard++;
          if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front(); seen_lock = e.lock; seen_ecnt = e.ecnt; n_chk++;
            if (obs_err !== e.err || obs_lock !== e.lock || obs_ecnt !== 32'(e.ecnt) ||
                (e.chk && (obs_len !== 32'(e.len) || obs_lvl !== e.lvl))) begin
              n_fail++;
              $display("FAIL lock_short@%0d: got err=%b lock=%b len=%0d lvl=%b cnt=%0d want err=%b lock=%b len=%0d lvl=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_len, obs_lvl, obs_ecnt, e.err, e.lock, e.len, e.lvl, e.ecnt);
            end
          end else begin
            n_chk++;
            if (obs_err !== 1'b0 || obs_lock !== seen_lock || obs_ecnt !== 32'(seen_ecnt)) begin
              n_fail++;
              $display("FAIL lock_short_steady@%0d: got err=%b lock=%b cnt=%0d want err=0 lock=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_ecnt, seen_lock, seen_ecnt);
            end
          end
        end
        n_chk++;
        if (guard >= 2000) begin n_fail++; $display("FAIL lock_short_timeout: got %0d pending want 0", sb.size()); end
      end
    join
  endtask

  task automatic test_timeout();
    exp_t e;
    int   guard;
    do_reset(0, 10, 255);
    stim_done = 1'b0;
    fork
      begin
        put_run(1, 10, 0, 0, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 1, 0);
        put_run(0, 10, 1, 0, 1, 0);
        put_run(1, 25, 1, 0, 1, 1);
        put_run(0, 10, 0, 0, 0, 0);
        put_run(1, 10, 1, 0, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        stim_done = 1'b1;
      end
      begin
        guard = 0;
        while ((!stim_done || sb.size() != 0) && guard < 2000) begin
          @(posedge clk); #2; guard++;
          if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front(); seen_lock = e.lock; seen_ecnt = e.ecnt; n_chk++;
            if (obs_err !== e.err || obs_lock !== e.lock || obs_ecnt !== 32'(e.ecnt) ||
                (e.chk && (obs_len !== 32'(e.len) || obs_lvl !== e.lvl))) begin
              n_fail++;
              $display("FAIL timeout@%0d: got err=%b lock=%b len=%0d lvl=%b cnt=%0d want err=%b lock=%b len=%0d lvl=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_len, obs_lvl, obs_ecnt, e.err, e.lock, e.len, e.lvl, e.ecnt);
            end
          end else begin
            n_chk++;
            if (obs_err !== 1'b0 || obs_lock !== seen_lock || obs_ecnt !== 32'(seen_ecnt)) begin
              n_fail++;
              $display("FAIL timeout_steady@%0d: got err=%b lock=%b cnt=%0d want err=0 lock=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_ecnt, seen_lock, seen_ecnt);
            end
          end
        end
        n_chk++;
        if (guard >= 2000) begin n_fail++; $display("FAIL timeout_bound: got %0d pending want 0", sb.size()); end
      end
    join
  endtask

  task automatic test_tolerance();
    exp_t e;
    int   guard;
    do_reset(1, 11, 255);
    stim_done = 1'b0;
    fork
      begin
        put_run(1,  9, 0, 0, 0, 0);
        put_run(0, 11, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 0, 0);
        put_run(0,  9, 1, 0, 0, 0);
        put_run(1,  8, 1, 0, 1, 0);
        put_run(0, 10, 1, 1, 0, 0);
        put_run(1, 10, 1, 0, 0, 0);
        stim_done = 1'b1;
      end
      begin
        guard = 0;
        while ((!stim_done || sb.size() != 0) && guard < 2000) begin
          @(posedge clk); #2; guard++;
          if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front(); seen_lock = e.lock; seen_ecnt = e.ecnt; n_chk++;
            if (obs_err !== e.err || obs_lock !== e.lock || obs_ecnt !== 32'(e.ecnt) ||
                (e.chk && (obs_len !== 32'(e.len) || obs_lvl !== e.lvl))) begin
              n_fail++;
              $display("FAIL tolerance@%0d: got err=%b lock=%b len=%0d lvl=%b cnt=%0d want err=%b lock=%b len=%0d lvl=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_len, obs_lvl, obs_ecnt, e.err, e.lock, e.len, e.lvl, e.ecnt);
            end
          end else begin
            n_chk++;
            if (obs_err !== 1'b0 || obs_lock !== seen_lock || obs_ecnt !== 32'(seen_ecnt)) begin
              n_fail++;
              $display("FAIL tolerance_steady@%0d: got err=%b lock=%b cnt=%0d want err=0 lock=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_ecnt, seen_lock, seen_ecnt);
            end
          end
        end
        n_chk++;
        if (guard >= 2000) begin n_fail++; $display("FAIL tolerance_bound: got %0d pending want 0", sb.size()); end
      end
    join
  endtask

  task automatic test_reset_relock();
    exp_t e;
    int   guard;
    do_reset(0, 10, 255);
    stim_done = 1'b0;
    fork
      begin
        put_run(1, 10, 0, 0, 0, 0);
        put_run(0,  5, 1, 0, 0, 0);
        put_run(1,  5, 1, 1, 0, 0);
        put_run(0,  5, 1, 1, 0, 0);
        put_run(1, 10, 1, 1, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 1, 0);
        put_run(0,  5, 1, 0, 1, 0);
        e.due = cyc + 1; e.err = 1'b0; e.lock = 1'b0; e.chk = 1'b1;
        e.len = 0; e.lvl = 1'b0; e.ecnt = 0;
        sb.push_back(e);
        rst_n = 1'b0; step(1'b0); rst_n = 1'b1;
        exp_ecnt = 0; prev_lvl = 1'b0; prev_len = 0;
        put_run(0,  3, 0, 0, 0, 0);
        put_run(1, 10, 0, 0, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        put_run(1, 10, 1, 0, 1, 0);
        put_run(0, 10, 1, 0, 1, 0);
        stim_done = 1'b1;
      end
      begin
        guard = 0;
        while ((!stim_done || sb.size() != 0) && guard < 2000) begin
          @(posedge clk); #2; guard++;
          if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front(); seen_lock = e.lock; seen_ecnt = e.ecnt; n_chk++;
            if (obs_err !== e.err || obs_lock !== e.lock || obs_ecnt !== 32'(e.ecnt) ||
                (e.chk && (obs_len !== 32'(e.len) || obs_lvl !== e.lvl))) begin
              n_fail++;
              $display("FAIL reset_relock@%0d: got err=%b lock=%b len=%0d lvl=%b cnt=%0d want err=%b lock=%b len=%0d lvl=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_len, obs_lvl, obs_ecnt, e.err, e.lock, e.len, e.lvl, e.ecnt);
            end
          end else begin
            n_chk++;
            if (obs_err !== 1'b0 || obs_lock !== seen_lock || obs_ecnt !== 32'(seen_ecnt)) begin
              n_fail++;
              $display("FAIL reset_relock_steady@%0d: got err=%b lock=%b cnt=%0d want err=0 lock=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_ecnt, seen_lock, seen_ecnt);
            end
          end
        end
        n_chk++;
        if (guard >= 2000) begin n_fail++; $display("FAIL reset_relock_bound: got %0d pending want 0", sb.size()); end
      end
    join
  endtask

  task automatic test_err_saturation();
    exp_t e;
    int   guard;
    do_reset(2, 10, 3);
    stim_done = 1'b0;
    fork
      begin
        put_run(1, 10, 0, 0, 0, 0);
        put_run(0,  5, 1, 0, 0, 0);
        put_run(1,  5, 1, 1, 0, 0);
        put_run(0,  5, 1, 1, 0, 0);
        put_run(1,  5, 1, 1, 0, 0);
        put_run(0,  5, 1, 1, 0, 0);
        put_run(1, 10, 1, 1, 0, 0);
        put_run(0, 10, 1, 0, 0, 0);
        stim_done = 1'b1;
      end
      begin
        guard = 0;
        while ((!stim_done || sb.size() != 0) && guard < 2000) begin
          @(posedge clk); #2; guard++;
          if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front(); seen_lock = e.lock; seen_ecnt = e.ecnt; n_chk++;
            if (obs_err !== e.err || obs_lock !== e.lock || obs_ecnt !== 32'(e.ecnt) ||
                (e.chk && (obs_len !== 32'(e.len) || obs_lvl !== e.lvl))) begin
              n_fail++;
              $display("FAIL err_sat@%0d: got err=%b lock=%b len=%0d lvl=%b cnt=%0d want err=%b lock=%b len=%0d lvl=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_len, obs_lvl, obs_ecnt, e.err, e.lock, e.len, e.lvl, e.ecnt);
            end
          end else begin
            n_chk++;
            if (obs_err !== 1'b0 || obs_lock !== seen_lock || obs_ecnt !== 32'(seen_ecnt)) begin
              n_fail++;
              $display("FAIL err_sat_steady@%0d: got err=%b lock=%b cnt=%0d want err=0 lock=%b cnt=%0d",
                       cyc, obs_err, obs_lock, obs_ecnt, seen_lock, seen_ecnt);
            end
          end
        end
        n_chk++;
        if (guard >= 2000) begin n_fail++; $display("FAIL err_sat_bound: got %0d pending want 0", sb.size()); end
      end
    join
  endtask

  initial begin
    test_reset();
    test_lock_and_short();
    test_timeout();
    test_tolerance();
    test_reset_relock();
    test_err_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pulse_pattern_checker.md
Name: pulse_pattern_checker

Overview:
- Receive-side checker for the square-wave test pattern driven by the pattern generator block on the CLB test path.
- Samples the single-bit pattern input and measures the run length of every high and low level.
- Declares lock after a programmable number of consecutive in-tolerance runs, and flags any run that is too short or too long.
- Drives lock/error status and diagnostic counters to the test harness (LEDs / logic-analyser taps).

Parameters:
- HALF_PERIOD, 10: expected length of each high and each low run, in clk cycles (>= 2).
- TOL, 0: allowed ± deviation of a run length, in cycles (TOL < HALF_PERIOD).
- LOCK_RUNS, 4: consecutive good runs required to assert lock (>= 1).
- CNT_W, 5: run-length counter width; must hold HALF_PERIOD+TOL+1.
- ERR_W, 8: error counter width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- d  in  1  pattern input under test.
- lock  out  1  1 = pattern locked.
- err  out  1  one-cycle pulse per detected error.
- last_len  out  CNT_W  length of the most recently completed (or timed-out) run.
- last_lvl  out  1  level of that run.
- err_cnt  out  ERR_W  saturating count of errors since reset.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset: while rst_n=0 at a clk edge, lock=0, err=0, last_len=0, last_lvl=0, err_cnt=0, state=IDLE, run counter=0, good counter=0, sample registers=0.
  - rst_n deasserting between edges has no effect until the next edge.
  - Reset mid-run discards the partial run.
- Sampling: d is registered into d_q.
  - Edge = d_q != d_prev, where d_prev is d_q delayed by one cycle.
  - Run counter: loads 1 on an edge, otherwise increments; it never exceeds HALF_PERIOD+TOL+1.
  - On an edge, completed length L = run counter value before the load, and completed level = d_prev.
- Latency: d captured at edge k shows its edge effects on outputs after edge k+1.
- Good run: HALF_PERIOD-TOL <= L <= HALF_PERIOD+TOL.
- States:
  - IDLE: run lengths ignored and no timeout. The first edge moves to MEASURE and starts a fresh run. The run in progress at reset is never judged.
  - MEASURE: on each edge, last_len=L and last_lvl=level.
    - Good run: good counter +1; when it reaches LOCK_RUNS, go to LOCKED and set lock=1.
    - Short run (L < HALF_PERIOD-TOL): err pulse, good counter=0, stay in MEASURE.
  - LOCKED: good run keeps lock=1. Short run: err pulse, lock=0 in the same cycle as err, good counter=0, go to MEASURE.
  - Timeout (MEASURE or LOCKED): no edge while the run counter already equals HALF_PERIOD+TOL causes the following at the next edge:
    - err pulse, last_len=HALF_PERIOD+TOL+1, last_lvl=d_q;
    - lock=0, good counter=0, state=IDLE.
    - A stuck input therefore produces exactly one error, and re-hunt starts at the next edge.
  - Edge and timeout are mutually exclusive by construction. An edge arriving exactly at count HALF_PERIOD+TOL is a good run.
- err is high for exactly one cycle per error.
- err_cnt increments by 1 per error and saturates at all-ones (no wrap).
- last_len and last_lvl hold between updates.

Optional Feature:
- Macro: PPC_INPUT_SYNC_EN.
- Defined: d passes through a two-flop synchronizer (flops reset to 0) ahead of d_q.
  - Latency increases by 2 cycles.
  - Measured lengths are unchanged.
- Undefined: d registered once only; d must be synchronous to clk.

Test Plan:
- Defaults; reset, then ideal 10-high/10-low waveform -> first edge enters MEASURE; lock=1 one cycle after the 4th judged edge; err never 1; err_cnt=0; last_len=10 each run.
- Locked; one high run of 9 -> at its falling edge: err=1 for one cycle, last_len=9, last_lvl=1, lock=0 same cycle, err_cnt=1; lock returns after 4 further good runs.
- Locked; d held 1 for 25 cycles -> single err one cycle after run count 10 with no edge; last_len=11, lock=0, state IDLE, err_cnt=1; next edge restarts measurement, no second error.
- TOL=1; runs 9, 11, 10, 9 -> lock asserts, no err; then a run of 8 -> err, last_len=8.
- rst_n low one cycle while locked with err_cnt=3 -> all outputs 0 after that edge; pattern continuing -> relock after first edge plus 4 good runs.
- ERR_W=2; five short runs -> err_cnt goes 1,2,3,3,3; five err pulses observed; repeat with PPC_INPUT_SYNC_EN defined -> identical results, delayed 2 cycles.
